// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one byte-wide serial transmitter among NUM_REQ sources.
// Runs the full Send/Sent handshake per byte, pulses ack to the winner, and can add an idle gap.
module tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 tx_send,
    output logic [7:0]           tx_din,
    input  logic                 tx_sent
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [GW:0]   NREQ_W   = (GW+1)'(NUM_REQ);
    localparam logic [15:0]   GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_din_q, tx_din_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [GW-1:0]      rr_last_q, rr_last_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;

    logic               found;
    logic [GW-1:0]      winner;
    logic [GW:0]        cand;
    logic [7:0]         win_byte;
    logic [NUM_REQ-1:0] grant_oh;

    // Scan starts one past the last winner so a repeat requester yields to any other.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, rr_last_q} + (GW+1)'(i);
            if (cand >= NREQ_W) cand = cand - NREQ_W;
            if (!found && req[cand[GW-1:0]]) begin
                found  = 1'b1;
                winner = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        win_byte = 8'h00;
        grant_oh = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == GW'(j)) win_byte = din[8*j +: 8];
            grant_oh[j] = (grant_id_q == GW'(j));
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        tx_send_d  = tx_send_q;
        tx_din_d   = tx_din_q;
        grant_id_d = grant_id_q;
        rr_last_d  = rr_last_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    tx_din_d   = win_byte;
                    grant_id_d = winner;
                    rr_last_d  = winner;
                    tx_send_d  = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_sent) begin
                    tx_send_d = 1'b0;
                    ack_d     = grant_oh;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (!tx_sent) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 16'd0) state_d = IDLE;
                else                    gap_cnt_d = gap_cnt_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ack_q      <= '0;
            tx_send_q  <= 1'b0;
            tx_din_q   <= 8'h00;
            grant_id_q <= '0;
            rr_last_q  <= GW'(NUM_REQ - 1);
            gap_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            tx_send_q  <= tx_send_d;
            tx_din_q   <= tx_din_d;
            grant_id_q <= grant_id_d;
            rr_last_q  <= rr_last_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ack      = ack_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_id_q;
    assign tx_send  = tx_send_q;
    assign tx_din   = tx_din_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: a no-gap instance for arbitration/handshake vectors and
// a 10-cycle-gap instance for inter-byte spacing.
module tb_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req1;
    logic [31:0] din;
    logic        tx_sent, tx_sent1;
    logic [3:0]  ack, ack1;
    logic        busy, busy1;
    logic [1:0]  grant_id, grant_id1;
    logic        tx_send, tx_send1;
    logic [7:0]  tx_din, tx_din1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] lane [4];

    typedef struct {
        logic [3:0] req;
        int         dly;
        int         exp_id;
    } row_t;
    row_t rows [13];

    always #5 clk = ~clk;

    tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .ack(ack), .busy(busy),
        .grant_id(grant_id), .tx_send(tx_send), .tx_din(tx_din), .tx_sent(tx_sent)
    );

    tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(10)) dut_gap (
        .clk(clk), .reset(reset), .req(req1), .din(din), .ack(ack1), .busy(busy1),
        .grant_id(grant_id1), .tx_send(tx_send1), .tx_din(tx_din1), .tx_sent(tx_sent1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Invariants: never more than one ack bit, never ack together with tx_send.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if ($countones(ack) > 1 || (ack != 4'b0 && tx_send))
                chk("ack_excl", {27'b0, tx_send, ack}, {28'b0, ack & {4{~tx_send}}} & 32'h0);
        end
    end

    task automatic run_byte(input logic [3:0] r, input int dly, input int exp_id, input string tag);
        logic hold_ok;
        req = r;
        @(negedge clk);
        chk({tag, "_send"}, 32'(tx_send), 32'd1);
        chk({tag, "_gid"},  32'(grant_id), 32'(exp_id));
        chk({tag, "_din"},  32'(tx_din), 32'(lane[exp_id]));
        chk({tag, "_ack0"}, 32'(ack), 32'd0);
        hold_ok = 1'b1;
        repeat (dly) begin
            @(negedge clk);
            if (tx_send !== 1'b1 || tx_din !== lane[exp_id] || ack !== 4'b0) hold_ok = 1'b0;
        end
        chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
        tx_sent = 1'b1;
        @(negedge clk);
        chk({tag, "_ack"},   32'(ack), 32'd1 << exp_id);
        chk({tag, "_drop"},  32'(tx_send), 32'd0);
        tx_sent = 1'b0;
        req     = 4'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(ack), 32'd0);
        chk({tag, "_idle"},  32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int gapc, idlec;
        logic saw_ack, saw_ack1;

        lane[0] = 8'h3C; lane[1] = 8'h5A; lane[2] = 8'hA5; lane[3] = 8'hC3;
        din = {lane[3], lane[2], lane[1], lane[0]};

        rows[0]  = '{4'hF, 2, 0};   rows[1]  = '{4'hF, 1, 1};
        rows[2]  = '{4'hF, 0, 2};   rows[3]  = '{4'hF, 3, 3};
        rows[4]  = '{4'hF, 1, 0};   rows[5]  = '{4'hF, 0, 1};
        rows[6]  = '{4'h4, 19, 2};  rows[7]  = '{4'h9, 1, 3};
        rows[8]  = '{4'h9, 2, 0};   rows[9]  = '{4'h3, 0, 1};
        rows[10] = '{4'h1, 1, 0};   rows[11] = '{4'h8, 0, 3};
        rows[12] = '{4'h6, 2, 1};

        // Reset with every request and tx_sent asserted.
        reset = 1'b0; req = 4'hF; tx_sent = 1'b1; req1 = 4'hF; tx_sent1 = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_send", 32'(tx_send), 32'd0);
        chk("rst_ack",  32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_din",  32'(tx_din), 32'h00);
        chk("rst_gid",  32'(grant_id), 32'd0);
        reset = 1'b1; req = 4'b0; tx_sent = 1'b0; req1 = 4'b0; tx_sent1 = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 13; k++)
            run_byte(rows[k].req, rows[k].dly, rows[k].exp_id, $sformatf("row%0d", k));

        // Reset while a byte is in flight; requester 0 must win again afterwards.
        req = 4'b0001;
        @(negedge clk);
        chk("mid_send", 32'(tx_send), 32'd1);
        chk("mid_din",  32'(tx_din), 32'h3C);
        req = 4'b0011;
        @(negedge clk);
        reset = 1'b0;
        saw_ack = 1'b0;
        @(negedge clk);
        if (ack != 4'b0) saw_ack = 1'b1;
        chk("mid_rst_send", 32'(tx_send), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        if (ack != 4'b0) saw_ack = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        if (ack != 4'b0) saw_ack = 1'b1;
        chk("mid_no_ack", 32'(saw_ack), 32'd0);
        chk("mid_regrant_send", 32'(tx_send), 32'd1);
        chk("mid_regrant_gid",  32'(grant_id), 32'd0);
        chk("mid_regrant_din",  32'(tx_din), 32'h3C);
        tx_sent = 1'b1;
        @(negedge clk);
        chk("mid_ack0", 32'(ack), 32'b0001);
        tx_sent = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("mid_next_gid", 32'(grant_id), 32'd1);
        chk("mid_next_din", 32'(tx_din), 32'h5A);
        tx_sent = 1'b1;
        @(negedge clk);
        chk("mid_ack1", 32'(ack), 32'b0010);
        tx_sent = 1'b0;
        req = 4'b0;
        @(negedge clk);

        // Requester 1 withdraws after a one-cycle pulse during SEND; spurious tx_sent in IDLE.
        req = 4'b0001;
        @(negedge clk);
        chk("wd_gid", 32'(grant_id), 32'd0);
        saw_ack = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        req = 4'b0001;
        @(negedge clk);
        tx_sent = 1'b1;
        @(negedge clk);
        chk("wd_ack0", 32'(ack), 32'b0001);
        tx_sent = 1'b0;
        req = 4'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack[1] || tx_send) saw_ack = 1'b1;
        end
        tx_sent = 1'b1;
        @(negedge clk);
        tx_sent = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack != 4'b0 || tx_send || busy) saw_ack = 1'b1;
        end
        chk("wd_quiet", 32'(saw_ack), 32'd0);
        run_byte(4'b0010, 1, 1, "wd_after");

        // Gap instance: two pending, first byte then count spacing to the second.
        req1 = 4'b0011;
        @(negedge clk);
        chk("gap_first_gid", 32'(grant_id1), 32'd0);
        chk("gap_first_send", 32'(tx_send1), 32'd1);
        @(negedge clk);
        tx_sent1 = 1'b1;
        @(negedge clk);
        chk("gap_ack0", 32'(ack1), 32'b0001);
        tx_sent1 = 1'b0;
        req1 = 4'b0010;
        gapc = 0; idlec = 0; saw_ack1 = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx_send1) break;
            if (ack1 != 4'b0) saw_ack1 = 1'b1;
            if (busy1) gapc++;
            else       idlec++;
        end
        chk("gap_busy_cycles", 32'(gapc), 32'd10);
        chk("gap_idle_cycles", 32'(idlec), 32'd1);
        chk("gap_no_ack", 32'(saw_ack1), 32'd0);
        chk("gap_second_send", 32'(tx_send1), 32'd1);
        chk("gap_second_gid", 32'(grant_id1), 32'd1);
        tx_sent1 = 1'b1;
        @(negedge clk);
        chk("gap_ack1", 32'(ack1), 32'b0010);
        tx_sent1 = 1'b0;
        req1 = 4'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
